// File: rtl/prng_multi_gen.sv
// Multi-channel Fibonacci-style LFSR generator with round-robin channel stepping,
// stop-code / word-limit termination and a one-deep valid/ready output slot.

module prng_lane #(
  parameter int DATA_WIDTH = 49
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic                  i_upd,
  input  logic [DATA_WIDTH-1:0] i_nxt,
  output logic [DATA_WIDTH-1:0] o_state
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       o_state <= '0;
    else if (i_load) o_state <= i_seed;
    else if (i_upd)  o_state <= i_nxt;
  end
endmodule

module prng_multi_gen #(
  parameter  int DATA_WIDTH = 49,
  parameter  int NUM_CH     = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mode,
  input  logic                  i_en,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_taps,
  input  logic [DATA_WIDTH-1:0] i_stop_code,
  input  logic [CNT_WIDTH-1:0]  i_max_cnt,
  input  logic                  i_ready,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CH_W-1:0]       o_ch,
  output logic                  o_done,
  output logic                  o_stop_hit,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    lane_q;
  logic [CNT_WIDTH-1:0]                 cnt_q, cnt_inc;
  logic [CH_W-1:0]                      ptr_q;
  logic [DATA_WIDTH-1:0]                seed_base, cur, nxt;
  logic                                 load, step, hit_stop, hit_max, term;

  function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] v, input int k);
    logic [2*DATA_WIDTH-1:0] d;
    d = {v, v} << (k % DATA_WIDTH);
    return d[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  // An all-zero seed would lock the LFSRs, so it is replaced by 1.
  assign seed_base = (i_data == '0) ? DATA_WIDTH'(1) : i_data;

  assign load     = (state_q == S_IDLE) && i_en;
  assign step     = (state_q == S_RUN) && (i_mode || i_step) && (!o_vld || i_ready);
  assign cur      = lane_q[ptr_q];
  assign nxt      = {cur[DATA_WIDTH-2:0], ^(cur & i_taps)};
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);
  assign hit_stop = (nxt == i_stop_code);
  assign hit_max  = (i_max_cnt != '0) && (cnt_inc == i_max_cnt);
  assign term     = step && (hit_stop || hit_max);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    prng_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (load),
      .i_seed  (rotl(seed_base, k)),
      .i_upd   (step && (ptr_q == CH_W'(k))),
      .i_nxt   (nxt),
      .o_state (lane_q[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_en) state_d = S_RUN;
      S_RUN:   if (term) state_d = S_DRAIN;
      S_DRAIN: if (!o_vld || i_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_done = (state_q == S_DONE);
  assign o_busy = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld      <= 1'b0;
      o_data     <= '0;
      o_ch       <= '0;
      o_stop_hit <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else if (load) begin
      o_stop_hit <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else if (step) begin
      o_vld  <= 1'b1;
      o_data <= nxt;
      o_ch   <= ptr_q;
      // Saturate so an unlimited run never wraps back into a limit match.
      if (cnt_q != '1) cnt_q <= cnt_inc;
      ptr_q  <= (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + CH_W'(1);
      if (hit_stop) o_stop_hit <= 1'b1;
    end else if (o_vld && i_ready) begin
      o_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prng_multi_gen.sv
// Directed, table-driven bench for prng_multi_gen (8-bit, 2 channels, taps B8).

module tb_prng_multi_gen;
  localparam int DW = 8;
  localparam int NC = 2;
  localparam int CW = 16;

  logic          i_clk, i_rst, i_mode, i_en, i_step, i_ready;
  logic [DW-1:0] i_data, i_taps, i_stop_code;
  logic [CW-1:0] i_max_cnt;
  logic          o_vld, o_done, o_stop_hit, o_busy;
  logic [DW-1:0] o_data;
  logic [0:0]    o_ch;

  prng_multi_gen #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_en(i_en), .i_step(i_step),
    .i_data(i_data), .i_taps(i_taps), .i_stop_code(i_stop_code), .i_max_cnt(i_max_cnt),
    .i_ready(i_ready), .o_vld(o_vld), .o_data(o_data), .o_ch(o_ch), .o_done(o_done),
    .o_stop_hit(o_stop_hit), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          mode, en, step, ready;
    logic [DW-1:0] data, stop;
    logic [CW-1:0] maxc;
    logic          vld;
    logic [DW-1:0] dat;
    logic          ch, done, hit, busy;
  } vec_t;

  vec_t          vq[$];
  logic          cfg_mode;
  logic [DW-1:0] cfg_data, cfg_stop;
  logic [CW-1:0] cfg_max;
  int            n_pass = 0;
  int            n_tot  = 0;

  // Packed as {vld, done, hit, busy, data, ch}.
  function automatic logic [12:0] pack_out();
    return {o_vld, o_done, o_stop_hit, o_busy, o_data, o_ch};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp,
                       input logic [12:0] mask);
    n_tot++;
    if ((act & mask) === (exp & mask)) n_pass++;
    else $display("FAIL %s: got vld/done/hit/busy/data/ch=%b/%b/%b/%b/%h/%b want %b/%b/%b/%b/%h/%b",
                  name, act[12], act[11], act[10], act[9], act[8:1], act[0],
                  exp[12], exp[11], exp[10], exp[9], exp[8:1], exp[0]);
  endtask

  function automatic void add(input logic en, input logic step, input logic ready,
                              input logic vld, input logic [DW-1:0] dat, input logic ch,
                              input logic done, input logic hit, input logic busy);
    vec_t v;
    v.mode = cfg_mode; v.data = cfg_data; v.stop = cfg_stop; v.maxc = cfg_max;
    v.en = en; v.step = step; v.ready = ready;
    v.vld = vld; v.dat = dat; v.ch = ch; v.done = done; v.hit = hit; v.busy = busy;
    vq.push_back(v);
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic run_vecs(input string name);
    foreach (vq[i]) begin
      i_mode = vq[i].mode; i_en = vq[i].en; i_step = vq[i].step; i_ready = vq[i].ready;
      i_data = vq[i].data; i_stop_code = vq[i].stop; i_max_cnt = vq[i].maxc;
      @(posedge i_clk); #1;
      check($sformatf("%s[%0d]", name, i), pack_out(),
            {vq[i].vld, vq[i].done, vq[i].hit, vq[i].busy, vq[i].dat, vq[i].ch},
            vq[i].vld ? 13'h1FFF : 13'h1E00);
    end
    vq.delete();
    i_en = 1'b0; i_step = 1'b0;
  endtask

  // Four-word run: 02/0, 04/1, 04/0, 08/1, DRAIN, DONE, IDLE.
  task automatic build_basic(input logic hit_last);
    add(1, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h02, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h04, 1, 0, 0, 1);
    add(0, 0, 1, 1, 8'h04, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h08, 1, 0, hit_last, 1);
    add(0, 0, 1, 0, 8'h00, 0, 1, hit_last, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, hit_last, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_mode = 1'b1; i_en = 1'b0; i_step = 1'b0; i_ready = 1'b1;
    i_data = 8'h01; i_taps = 8'hB8; i_stop_code = 8'hFF; i_max_cnt = '0;
    #12;
    check("reset_state", pack_out(), 13'h0, 13'h1FFF);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Word-limit termination.
    cfg_mode = 1; cfg_data = 8'h01; cfg_stop = 8'hFF; cfg_max = 16'd4;
    build_basic(1'b0);
    run_vecs("maxcnt");

    // Stop-code termination with unlimited count; sticky hit persists into IDLE.
    cfg_max = 16'd0; cfg_stop = 8'h08;
    build_basic(1'b1);
    run_vecs("stopcode");

    // Reset in IDLE clears the sticky stop flag.
    #2 i_rst = 1'b1; #1;
    check("rst_idle", pack_out(), 13'h0, 13'h1FFF);
    @(posedge i_clk); #1 i_rst = 1'b0;

    // Reset mid-run after the second word, then restart from the seed.
    i_max_cnt = 16'd4; i_stop_code = 8'hFF; i_mode = 1'b1;
    i_en = 1'b1; @(posedge i_clk); #1 i_en = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    check("pre_rst_word2", pack_out(), {1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1}, 13'h1FFF);
    #2 i_rst = 1'b1; #1;
    check("rst_async", pack_out(), 13'h0, 13'h1FFF);
    @(posedge i_clk); #1;
    check("rst_held", pack_out(), 13'h0, 13'h1FFF);
    i_rst = 1'b0;
    cfg_max = 16'd4; cfg_stop = 8'hFF;
    build_basic(1'b0);
    run_vecs("restart");

    // Backpressure: first word held for three cycles, nothing lost.
    add(1, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h02, 0, 0, 0, 1);
    add(0, 0, 0, 1, 8'h02, 0, 0, 0, 1);
    add(0, 0, 0, 1, 8'h02, 0, 0, 0, 1);
    add(0, 0, 0, 1, 8'h02, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h04, 1, 0, 0, 1);
    add(0, 0, 1, 1, 8'h04, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h08, 1, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
    run_vecs("backpressure");

    // External stepping every third cycle; a mid-run i_en must not reload.
    cfg_mode = 0;
    add(1, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 1, 1, 1, 8'h02, 0, 0, 0, 1);
    add(1, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 1, 1, 1, 8'h04, 1, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 1, 1, 1, 8'h04, 0, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    add(0, 1, 1, 1, 8'h08, 1, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
    add(0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    run_vecs("extstep");

    // Zero seed behaves as seed 01.
    cfg_mode = 1; cfg_data = 8'h00;
    build_basic(1'b0);
    run_vecs("zeroseed");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/prng_multi_gen.md
PRNG_MULTI_GEN -- requirements
Module: prng_multi_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 49, width of seed, taps, stop code and output word.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent LFSR channels (>=1).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the output-word counter and limit.
REQ-004 SHALL have one clock; reset is asynchronous and active-high: i_clk  input  1  clock, rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_mode  input  1  1 = internal free-run stepping, 0 = external stepping by i_step.
REQ-007 i_en  input  1  start pulse; loads seeds, clears counter, starts run; ignored outside IDLE.
REQ-008 i_step  input  1  step request, used only when i_mode=0.
REQ-009 i_data  input  DATA_WIDTH  seed.
REQ-010 i_taps  input  DATA_WIDTH  feedback tap mask, sampled every step.
REQ-011 i_stop_code  input  DATA_WIDTH  value that terminates the run when generated.
REQ-012 i_max_cnt  input  CNT_WIDTH  word limit; 0 = unlimited.
REQ-013 i_ready  input  1  downstream accepts o_data when high with o_vld.
REQ-014 o_vld  output  1  o_data/o_ch valid.
REQ-015 o_data  output  DATA_WIDTH  generated word.
REQ-016 o_ch  output  max(1,$clog2(NUM_CH))  channel that produced o_data.
REQ-017 o_done  output  1  one-cycle end-of-run pulse.
REQ-018 o_stop_hit  output  1  sticky: run ended on stop-code match.
REQ-019 o_busy  output  1  high in RUN and DRAIN.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on i_en; RUN->DRAIN on terminate; DRAIN->DONE when output slot empty or accepted; DONE->IDLE unconditionally; illegal state ->IDLE.
REQ-021 On i_en in IDLE: channel k state = i_data rotated left by k (i_data=0 substitutes 1), counter=0, round-robin pointer=0, o_stop_hit=0.
REQ-022 Step condition in RUN: (i_mode ? 1 : i_step) AND (!o_vld OR i_ready).
REQ-023 Step: ch=pointer; fb = XOR-reduce(state[ch] & i_taps); next = {state[ch][DATA_WIDTH-2:0], fb}; state[ch], o_data <= next; o_ch <= ch; o_vld <= 1; counter++; pointer wraps NUM_CH-1 -> 0.
REQ-024 Latency: i_en at edge N; first step at edge N+1 (internal mode); o_vld high from N+1.
REQ-025 o_vld && i_ready with no step that cycle clears o_vld; o_vld && !i_ready holds o_data/o_ch/o_vld and all LFSR states stable.
REQ-026 Terminate on step where next == i_stop_code (sets o_stop_hit) or (i_max_cnt != 0 and counter+1 == i_max_cnt); both true: terminate once, o_stop_hit=1.
REQ-027 No steps in DRAIN, DONE or IDLE; o_done=1 exactly in DONE state.
REQ-028 Counter saturates at all-ones when i_max_cnt=0 (run continues until stop code).

Reset
REQ-029 i_rst high: state IDLE, o_vld=0, o_data=0, o_ch=0, o_done=0, o_stop_hit=0, o_busy=0, LFSR states=0, counter=0, pointer=0, immediately and at any point in a run.

Verification (DATA_WIDTH=8, NUM_CH=2, i_taps=8'hB8, i_data=8'h01, i_mode=1, i_ready=1 unless stated)
REQ-030 i_max_cnt=4, stop 8'hFF: o_data/o_ch = 02/0, 04/1, 04/0, 08/1 on consecutive cycles, then o_done one cycle later after DRAIN, o_stop_hit=0.
REQ-031 i_max_cnt=0, i_stop_code=8'h08: run ends at 4th word (08, ch1), o_stop_hit=1, o_done pulse, o_busy low after.
REQ-032 i_ready=0 for 3 cycles after first word: o_data holds 02, ch 0; on i_ready=1 next word 04/1, no words lost.
REQ-033 i_mode=0, i_step pulsed every 3rd cycle: one word per pulse, same sequence as REQ-030; i_en during RUN ignored.
REQ-034 i_rst asserted after 2nd word: all outputs 0 next sample; new i_en restarts sequence at 02/0.
REQ-035 i_data=0: behaves as seed 8'h01 (sequence of REQ-030).
